// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 4-stage IF/DOF/EX/WB pipeline.
// Tracks the EX/WB destinations, stalls on RAW hazards, and flushes on taken branches.
module pipe_hazard_ctrl #(
  parameter int REG_AW    = 5,
  parameter int CNT_W     = 16,
  parameter int WB_HAZARD = 1
) (
  input  logic              CLOCK,
  input  logic              RESET,
  input  logic              DOF_VALID,
  input  logic [REG_AW-1:0] AA,
  input  logic [REG_AW-1:0] BA,
  input  logic              USE_A,
  input  logic              USE_B,
  input  logic              RW,
  input  logic [REG_AW-1:0] DA,
  input  logic              BR_TAKEN,
  output logic              STALL,
  output logic              BUBBLE,
  output logic              FLUSH,
  output logic [REG_AW-1:0] EX_DA_Q,
  output logic              EX_RW_Q,
  output logic [CNT_W-1:0]  STALL_CNT,
  output logic [CNT_W-1:0]  FLUSH_CNT
);

  localparam logic WB_EN = (WB_HAZARD != 0);

  logic              r_ex_rw, r_wb_rw;
  logic [REG_AW-1:0] r_ex_da, r_wb_da;
  logic [CNT_W-1:0]  r_stall_cnt, r_flush_cnt;

  logic w_match_a, w_match_b, w_hazard, w_stall, w_flush, w_bubble;

  // R0 is hardwired zero, so a write to it can never create a dependency.
  assign w_match_a = (AA != '0) &&
                     ((r_ex_rw && (r_ex_da == AA)) || (WB_EN && r_wb_rw && (r_wb_da == AA)));
  assign w_match_b = (BA != '0) &&
                     ((r_ex_rw && (r_ex_da == BA)) || (WB_EN && r_wb_rw && (r_wb_da == BA)));

  assign w_hazard = DOF_VALID && ((USE_A && w_match_a) || (USE_B && w_match_b));
  assign w_flush  = BR_TAKEN;
  // The squashed DOF instruction makes any stall pointless, so the branch wins.
  assign w_stall  = w_hazard && !BR_TAKEN;
  assign w_bubble = w_stall || w_flush || !DOF_VALID;

  // State advances on the falling edge, in step with the pipeline registers.
  always_ff @(negedge CLOCK) begin
    if (RESET) begin
      r_ex_rw     <= 1'b0;
      r_ex_da     <= '0;
      r_wb_rw     <= 1'b0;
      r_wb_da     <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_wb_rw <= r_ex_rw;
      r_wb_da <= r_ex_da;
      if (w_bubble) begin
        r_ex_rw <= 1'b0;
        r_ex_da <= '0;
      end else begin
        r_ex_rw <= RW;
        r_ex_da <= DA;
      end
      if (w_stall && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
      if (w_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + CNT_W'(1);
    end
  end

  assign STALL     = w_stall;
  assign BUBBLE    = w_bubble;
  assign FLUSH     = w_flush;
  assign EX_DA_Q   = r_ex_da;
  assign EX_RW_Q   = r_ex_rw;
  assign STALL_CNT = r_stall_cnt;
  assign FLUSH_CNT = r_flush_cnt;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: three controllers (WB hazard on, WB hazard off, 2-bit counters)
// share one directed stimulus stream; expected results are queued per cycle.
module tb_pipe_hazard_ctrl;

  logic       CLOCK = 1'b0;
  logic       RESET, DOF_VALID, USE_A, USE_B, RW, BR_TAKEN;
  logic [4:0] AA, BA, DA;

  logic       s1, b1, f1, x1;
  logic [4:0] d1;
  logic [15:0] sc1, fc1;
  logic       s0, b0, f0, x0;
  logic [4:0] d0;
  logic [15:0] sc0, fc0;
  logic       sS, bS, fS, xS;
  logic [4:0] dS;
  logic [1:0] scS, fcS;

  always #5 CLOCK = ~CLOCK;

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .WB_HAZARD(1)) dut1 (
    .CLOCK(CLOCK), .RESET(RESET), .DOF_VALID(DOF_VALID), .AA(AA), .BA(BA),
    .USE_A(USE_A), .USE_B(USE_B), .RW(RW), .DA(DA), .BR_TAKEN(BR_TAKEN),
    .STALL(s1), .BUBBLE(b1), .FLUSH(f1), .EX_DA_Q(d1), .EX_RW_Q(x1),
    .STALL_CNT(sc1), .FLUSH_CNT(fc1));

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(16), .WB_HAZARD(0)) dut0 (
    .CLOCK(CLOCK), .RESET(RESET), .DOF_VALID(DOF_VALID), .AA(AA), .BA(BA),
    .USE_A(USE_A), .USE_B(USE_B), .RW(RW), .DA(DA), .BR_TAKEN(BR_TAKEN),
    .STALL(s0), .BUBBLE(b0), .FLUSH(f0), .EX_DA_Q(d0), .EX_RW_Q(x0),
    .STALL_CNT(sc0), .FLUSH_CNT(fc0));

  pipe_hazard_ctrl #(.REG_AW(5), .CNT_W(2), .WB_HAZARD(1)) dutS (
    .CLOCK(CLOCK), .RESET(RESET), .DOF_VALID(DOF_VALID), .AA(AA), .BA(BA),
    .USE_A(USE_A), .USE_B(USE_B), .RW(RW), .DA(DA), .BR_TAKEN(BR_TAKEN),
    .STALL(sS), .BUBBLE(bS), .FLUSH(fS), .EX_DA_Q(dS), .EX_RW_Q(xS),
    .STALL_CNT(scS), .FLUSH_CNT(fcS));

  typedef struct {
    int   cyc;
    logic chk, v, f, s1, s0, ex1, ex0;
    int   sc1, sc0, fc;
  } exp_t;

  exp_t q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   n_cyc   = 0;
  logic done    = 1'b0;

  task automatic cmp(input string name, input int cyc, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, act, exp);
    end
  endtask

  // Monitor: outputs are sampled on the rising edge, midway between active edges.
  always @(posedge CLOCK) begin
    if (q.size() != 0) begin
      exp_t e;
      e = q.pop_front();
      if (e.chk) begin
        cmp("d1.STALL",     e.cyc, int'(s1),  int'(e.s1));
        cmp("d1.FLUSH",     e.cyc, int'(f1),  int'(e.f));
        cmp("d1.BUBBLE",    e.cyc, int'(b1),  int'(e.s1 | e.f | !e.v));
        cmp("d1.EX_RW_Q",   e.cyc, int'(x1),  int'(e.ex1));
        cmp("d1.STALL_CNT", e.cyc, int'(sc1), e.sc1);
        cmp("d1.FLUSH_CNT", e.cyc, int'(fc1), e.fc);
        cmp("d0.STALL",     e.cyc, int'(s0),  int'(e.s0));
        cmp("d0.FLUSH",     e.cyc, int'(f0),  int'(e.f));
        cmp("d0.BUBBLE",    e.cyc, int'(b0),  int'(e.s0 | e.f | !e.v));
        cmp("d0.EX_RW_Q",   e.cyc, int'(x0),  int'(e.ex0));
        cmp("d0.STALL_CNT", e.cyc, int'(sc0), e.sc0);
        cmp("d0.FLUSH_CNT", e.cyc, int'(fc0), e.fc);
        cmp("dS.STALL",     e.cyc, int'(sS),  int'(e.s1));
        cmp("dS.STALL_CNT", e.cyc, int'(scS), (e.sc1 > 3) ? 3 : e.sc1);
        cmp("dS.FLUSH_CNT", e.cyc, int'(fcS), (e.fc > 3) ? 3 : e.fc);
      end
    end
  end

  task automatic cyc(input logic rst, input logic v, input int aa, input int ba,
                     input logic ua, input logic ub, input logic rw, input int da,
                     input logic br, input logic chk, input logic es1, input logic es0,
                     input logic ex1, input logic ex0, input int esc1, input int esc0,
                     input int efc);
    exp_t e;
    @(negedge CLOCK);
    #1;
    RESET = rst; DOF_VALID = v; AA = 5'(aa); BA = 5'(ba);
    USE_A = ua; USE_B = ub; RW = rw; DA = 5'(da); BR_TAKEN = br;
    e.cyc = n_cyc; e.chk = chk; e.v = v; e.f = br;
    e.s1 = es1; e.s0 = es0; e.ex1 = ex1; e.ex0 = ex0;
    e.sc1 = esc1; e.sc0 = esc0; e.fc = efc;
    q.push_back(e);
    n_cyc++;
  endtask

  initial begin
    RESET = 1'b1; DOF_VALID = 1'b0; AA = '0; BA = '0; USE_A = 1'b0; USE_B = 1'b0;
    RW = 1'b0; DA = '0; BR_TAKEN = 1'b0;
    //  rst v  aa ba ua ub rw da br   chk s1 s0 x1 x0 sc1 sc0 fc
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    // back-to-back R3 producer/consumer
    cyc(0, 1, 0, 0, 0, 0, 1, 3, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 1, 3, 0, 1, 0, 1, 7, 0,   1, 1, 1, 1, 1, 0, 0, 0);
    cyc(0, 1, 3, 0, 1, 0, 1, 7, 0,   1, 1, 0, 0, 0, 1, 1, 0);
    cyc(0, 1, 3, 0, 1, 0, 1, 7, 0,   1, 0, 0, 0, 1, 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 2, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 2, 1, 0);
    // distance-2 R5 dependency on source B
    cyc(0, 1, 0, 0, 0, 0, 1, 5, 0,   1, 0, 0, 0, 0, 2, 1, 0);
    cyc(0, 1, 1, 2, 1, 1, 1, 6, 0,   1, 0, 0, 1, 1, 2, 1, 0);
    cyc(0, 1, 0, 5, 0, 1, 0, 0, 0,   1, 1, 0, 1, 1, 2, 1, 0);
    cyc(0, 1, 0, 5, 0, 1, 0, 0, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    // same sequence with an immediate in place of source B
    cyc(0, 1, 0, 0, 0, 0, 1, 5, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    cyc(0, 1, 1, 2, 1, 1, 1, 6, 0,   1, 0, 0, 1, 1, 3, 1, 0);
    cyc(0, 1, 0, 5, 0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    // write to R0 then read R0
    cyc(0, 1, 0, 0, 0, 0, 1, 0, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    cyc(0, 1, 0, 0, 1, 1, 0, 0, 0,   1, 0, 0, 1, 1, 3, 1, 0);
    cyc(0, 1, 0, 0, 1, 1, 0, 0, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    // hazard coincident with taken branch, then a second consecutive flush
    cyc(0, 1, 0, 0, 0, 0, 1, 4, 0,   1, 0, 0, 0, 0, 3, 1, 0);
    cyc(0, 1, 4, 0, 1, 0, 1, 8, 1,   1, 0, 0, 1, 1, 3, 1, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 3, 1, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 3, 1, 2);
    // another 2-cycle stall pushes the 2-bit counter into saturation
    cyc(0, 1, 0, 0, 0, 0, 1, 9, 0,   1, 0, 0, 0, 0, 3, 1, 2);
    cyc(0, 1, 0, 9, 0, 1, 0, 0, 0,   1, 1, 1, 1, 1, 3, 1, 2);
    cyc(0, 1, 0, 9, 0, 1, 0, 0, 0,   1, 1, 0, 0, 0, 4, 2, 2);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 5, 2, 2);
    // reset in the first stall cycle
    cyc(0, 1, 0, 0, 0, 0, 1, 3, 0,   1, 0, 0, 0, 0, 5, 2, 2);
    cyc(1, 1, 3, 0, 1, 0, 0, 0, 0,   1, 1, 1, 1, 1, 5, 2, 2);
    cyc(0, 1, 3, 0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0, 0);
    done = 1'b1;
  end

  initial begin
    wait (done);
    for (int i = 0; i < 10 && q.size() != 0; i++) @(negedge CLOCK);
    n_tests++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: stimulus did not complete, expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 4-stage RISC pipeline (IF, DOF, EX, WB).
- Tracks destination registers of the instructions in flight in EX and WB.
- Detects read-after-write hazards against the DOF stage's source registers AA and BA, and stalls IF/DOF while inserting bubbles into EX.
- Squashes IF and DOF when EX resolves a taken branch, and keeps stall and flush event counters.

Parameters:
- REG_AW, 5, register address width (matches AA/BA/DA).
- CNT_W, 16, width of the stall and flush event counters.
- WB_HAZARD, 1: 1 = a WB-stage destination match also stalls (register file not write-through); 0 = only EX matches stall.

Ports:
- CLOCK  in  1  pipeline clock; all state updates on the falling edge, same as the pipeline registers.
- RESET  in  1  synchronous, active-high reset, sampled on the controller's active (falling) CLOCK edge.
- DOF_VALID  in  1  DOF stage holds a real instruction.
- AA  in  REG_AW  DOF source A address.
- BA  in  REG_AW  DOF source B address.
- USE_A  in  1  DOF instruction reads BUS_A from the register file.
- USE_B  in  1  DOF instruction reads BUS_B from the register file (0 when the constant/immediate is selected).
- RW  in  1  DOF instruction writes the register file.
- DA  in  REG_AW  DOF destination address.
- BR_TAKEN  in  1  EX stage resolved a taken branch/jump this cycle.
- STALL  out  1  hold PC and the IF/DOF pipeline registers.
- BUBBLE  out  1  force the DOF->EX control word to NOP (RW=0, MW=0, PS/BS inactive).
- FLUSH  out  1  clear the IF->DOF and DOF->EX pipeline registers to NOP.
- EX_DA_Q  out  REG_AW  tracked EX destination (debug).
- EX_RW_Q  out  1  tracked EX write enable (debug).
- STALL_CNT  out  CNT_W  saturating count of stall cycles.
- FLUSH_CNT  out  CNT_W  saturating count of flush events.

Behaviour:
- Internal state: EX slot {ex_rw, ex_da} and WB slot {wb_rw, wb_da}, plus the two counters.
- Reset, on an active edge with RESET=1: ex_rw=0, wb_rw=0, ex_da=0, wb_da=0, STALL_CNT=0, FLUSH_CNT=0.
  - Outputs after reset with DOF_VALID=0 and BR_TAKEN=0: STALL=0, BUBBLE=1, FLUSH=0.
  - RESET overrides all other inputs, including in the middle of a stall or flush.
- Match terms (combinational):
  - matchX(a) = (a != 0) and ((ex_rw and ex_da == a) or (WB_HAZARD and wb_rw and wb_da == a)).
  - R0 never matches.
- hazard = DOF_VALID and ((USE_A and matchX(AA)) or (USE_B and matchX(BA))).
- Outputs (combinational, same cycle):
  - FLUSH = BR_TAKEN.
  - STALL = hazard and not BR_TAKEN. A taken branch has priority because the stalled DOF instruction is squashed anyway.
  - BUBBLE = STALL or FLUSH or not DOF_VALID.
- Slot update on each active edge (RESET=0):
  - {wb_rw, wb_da} <= {ex_rw, ex_da}.
  - If BUBBLE: ex_rw <= 0, ex_da <= 0. Otherwise ex_rw <= RW, ex_da <= DA.
- Latency: a dependent instruction directly behind its producer stalls 2 cycles when WB_HAZARD=1, or 1 cycle when WB_HAZARD=0. Distance 2 stalls 1 cycle when WB_HAZARD=1 and 0 when WB_HAZARD=0. Distance 3 or more never stalls.
- The maximum consecutive STALL run is 2 (WB_HAZARD=1) or 1 (WB_HAZARD=0); a longer run is a design error.
- Counters:
  - STALL_CNT increments on every active edge where STALL=1.
  - FLUSH_CNT increments on every active edge where FLUSH=1.
  - Both saturate at 2^CNT_W-1; there is no wrap-around.
- Simultaneous events:
  - BR_TAKEN together with a hazard gives FLUSH=1, STALL=0, BUBBLE=1; only FLUSH_CNT increments.
  - BR_TAKEN on consecutive cycles flushes each cycle.
- DA=0 with RW=1 is tracked but never causes a stall.

Test Plan:
- RESET=1 for 2 edges, then DOF_VALID=0 -> STALL=0, FLUSH=0, BUBBLE=1, EX_RW_Q=0, both counters 0.
- Producer R3<-, immediately followed by a consumer with AA=3 and USE_A=1 (WB_HAZARD=1) -> STALL=1 for exactly 2 cycles with BUBBLE=1, then STALL=0; STALL_CNT=2. With WB_HAZARD=0 -> 1 stall cycle; STALL_CNT=1.
- Producer R5<-, one independent instruction, then a consumer with BA=5 and USE_B=1 -> 1 stall cycle. Same sequence with USE_B=0 (immediate operand) -> 0 stalls.
- Write to R0 (RW=1, DA=0), followed by a reader of R0 -> no stall; STALL_CNT unchanged.
- Hazard pending while BR_TAKEN=1 in the same cycle -> FLUSH=1, STALL=0, BUBBLE=1; EX_RW_Q=0 on the next cycle; FLUSH_CNT=1, STALL_CNT unchanged.
- RESET asserted in the first stall cycle of a 2-cycle stall -> next cycle EX_RW_Q=0, STALL=0, counters 0. Separately, preload (force) STALL_CNT to 0xFFFE and apply 3 stall cycles -> STALL_CNT holds at 0xFFFF.
